// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, datapath widths and the write-back FSM encoding.
package pipe_pkg;

   localparam int unsigned PIPE_XLEN = 64;
   localparam int unsigned REG_IDX_W = 6;

   localparam logic [5:0] OP_NOP  = 6'b000000;
   localparam logic [5:0] OP_MOV  = 6'b000001;
   localparam logic [5:0] OP_LD   = 6'b000010;
   localparam logic [5:0] OP_STR  = 6'b000011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNEQ = 6'b000101;
   localparam logic [5:0] OP_ALU  = 6'b000110;
   localparam logic [5:0] OP_LDI  = 6'b000111;
   localparam logic [5:0] OP_STRI = 6'b001000;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StHold    = 2'd1,
      StWaitMem = 2'd2
   } wb_state_e;

endpackage

// File: rtl/wb_commit_if.sv
// Handshake between the write-back decoder (master) and the commit stage (slave).
interface wb_commit_if #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned IDX_W = 6
);
   logic             in_valid;
   logic             in_ready;
   logic             write_reg;
   logic             from_mem;
   logic [IDX_W-1:0] reg_index;
   logic [XLEN-1:0]  alu_result;
   logic [XLEN-1:0]  mem_rdata;
   logic             mem_rdata_valid;
   logic             stall;

   modport master (
      output in_valid, write_reg, from_mem, reg_index, alu_result, mem_rdata, mem_rdata_valid,
      input  in_ready, stall
   );

   modport slave (
      input  in_valid, write_reg, from_mem, reg_index, alu_result, mem_rdata, mem_rdata_valid,
      output in_ready, stall
   );
endinterface

// File: rtl/wb_regfile.sv
// Architectural register file: one write port, two combinational read ports with write bypass.
module wb_regfile
   import pipe_pkg::*;
#(
   parameter int unsigned NREGS = 64,
   parameter int unsigned XLEN  = PIPE_XLEN,
   parameter int unsigned IDX_W = REG_IDX_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [XLEN-1:0]  wr_data,
   input  logic [IDX_W-1:0] rd_a_idx,
   input  logic [IDX_W-1:0] rd_b_idx,
   output logic [XLEN-1:0]  rd_a_data,
   output logic [XLEN-1:0]  rd_b_data
);

   logic [XLEN-1:0] rf_q [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            rf_q[i] <= '0;
         end
      end else if (we) begin
         rf_q[wr_idx] <= wr_data;
      end
   end

   // A write committing this cycle is visible to decode before the edge lands it.
   always_comb begin
      rd_a_data = rf_q[rd_a_idx];
      rd_b_data = rf_q[rd_b_idx];
      if (we && (wr_idx == rd_a_idx)) rd_a_data = wr_data;
      if (we && (wr_idx == rd_b_idx)) rd_b_data = wr_data;
   end

endmodule

// File: rtl/wb_commit_stage.sv
// Write-back commit stage: holds one instruction, merges ALU/load results, commits to the RF.
module wb_commit_stage
   import pipe_pkg::*;
#(
   parameter int unsigned NREGS = 64,
   parameter int unsigned XLEN  = PIPE_XLEN,
   parameter int unsigned CNT_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   wb_commit_if.slave           wb,
   input  logic [REG_IDX_W-1:0] rd_a_idx,
   input  logic [REG_IDX_W-1:0] rd_b_idx,
   output logic [XLEN-1:0]      rd_a_data,
   output logic [XLEN-1:0]      rd_b_data,
   output logic [CNT_W-1:0]     retire_count
);

   wb_state_e state_q, state_d;

   logic                 write_reg_q;
   logic                 from_mem_q;
   logic [REG_IDX_W-1:0] reg_index_q;
   logic [XLEN-1:0]      alu_result_q;
   logic [CNT_W-1:0]     retire_count_q;

   logic            stall;
   logic            accept;
   logic            complete;
   logic            rf_we;
   logic [XLEN-1:0] wr_data;

   // mem_rdata_valid only matters while a load is held.
   always_comb begin
      state_d  = state_q;
      complete = 1'b0;
      stall    = 1'b0;
      unique case (state_q)
         StIdle:    complete = 1'b0;
         StHold:    complete = 1'b1;
         StWaitMem: begin
            complete = wb.mem_rdata_valid;
            stall    = ~wb.mem_rdata_valid;
         end
         default:   complete = 1'b0;
      endcase
      accept = wb.in_valid & ~stall;
      if (accept) begin
         state_d = wb.from_mem ? StWaitMem : StHold;
      end else if (complete) begin
         state_d = StIdle;
      end
   end

   assign wb.stall    = stall;
   assign wb.in_ready = ~stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_reg_q  <= 1'b0;
         from_mem_q   <= 1'b0;
         reg_index_q  <= '0;
         alu_result_q <= '0;
      end else if (accept) begin
         write_reg_q  <= wb.write_reg;
         from_mem_q   <= wb.from_mem;
         reg_index_q  <= wb.reg_index;
         alu_result_q <= wb.alu_result;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retire_count_q <= '0;
      end else if (complete) begin
         retire_count_q <= retire_count_q + CNT_W'(1);
      end
   end

   assign retire_count = retire_count_q;
   assign rf_we        = complete & write_reg_q;
   assign wr_data      = from_mem_q ? wb.mem_rdata : alu_result_q;

   wb_regfile #(
      .NREGS (NREGS),
      .XLEN  (XLEN),
      .IDX_W (REG_IDX_W)
   ) u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (rf_we),
      .wr_idx    (reg_index_q),
      .wr_data   (wr_data),
      .rd_a_idx  (rd_a_idx),
      .rd_b_idx  (rd_b_idx),
      .rd_a_data (rd_a_data),
      .rd_b_data (rd_b_data)
   );

endmodule

// File: tb/tb_wb_commit_stage.sv
// Scoreboard bench for wb_commit_stage: commits queued at accept, checked after completion.
module tb_wb_commit_stage;

   logic        clk;
   logic        rst_n;
   logic [5:0]  rd_a_idx;
   logic [5:0]  rd_b_idx;
   logic [63:0] rd_a_data;
   logic [63:0] rd_b_data;
   logic [31:0] retire_count;

   int checks;
   int failures;

   typedef struct {
      logic        we;
      logic [5:0]  idx;
      logic [63:0] data;
   } sb_t;

   sb_t         sb_q[$];
   logic [63:0] model_rf [64];
   logic [31:0] model_cnt;

   wb_commit_if #(.XLEN(64), .IDX_W(6)) wbi ();

   wb_commit_stage #(
      .NREGS (64),
      .XLEN  (64),
      .CNT_W (32)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wb           (wbi),
      .rd_a_idx     (rd_a_idx),
      .rd_b_idx     (rd_b_idx),
      .rd_a_data    (rd_a_data),
      .rd_b_data    (rd_b_data),
      .retire_count (retire_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive_instr(input logic v, input logic wr, input logic fm,
                              input logic [5:0] idx, input logic [63:0] alu);
      wbi.in_valid   = v;
      wbi.write_reg  = wr;
      wbi.from_mem   = fm;
      wbi.reg_index  = idx;
      wbi.alu_result = alu;
   endtask

   function automatic void sb_push(input logic we, input logic [5:0] idx, input logic [63:0] d);
      sb_t e;
      e.we   = we;
      e.idx  = idx;
      e.data = d;
      sb_q.push_back(e);
   endfunction

   // Retire the oldest expected commit into the reference model.
   function automatic void sb_pop();
      sb_t e;
      e = sb_q.pop_front();
      if (e.we) model_rf[e.idx] = e.data;
      model_cnt = model_cnt + 32'd1;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 64; i++) model_rf[i] = '0;
      model_cnt = '0;
      sb_q.delete();
   endfunction

   task automatic test_reset();
      for (int i = 0; i < 64; i++) begin
         rd_a_idx = 6'(i);
         rd_b_idx = 6'(63 - i);
         #1;
         checks++;
         if (rd_a_data !== 64'd0) begin
            failures++;
            $display("FAIL reset_rd_a idx=%0d got=%h exp=0", i, rd_a_data);
         end
         checks++;
         if (rd_b_data !== 64'd0) begin
            failures++;
            $display("FAIL reset_rd_b idx=%0d got=%h exp=0", 63 - i, rd_b_data);
         end
      end
      checks++;
      if (retire_count !== 32'd0) begin
         failures++;
         $display("FAIL reset_count got=%0d exp=0", retire_count);
      end
      checks++;
      if (wbi.stall !== 1'b0 || wbi.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_stall got stall=%b ready=%b exp stall=0 ready=1",
                  wbi.stall, wbi.in_ready);
      end
   endtask

   task automatic test_alu();
      @(negedge clk);
      drive_instr(1'b1, 1'b1, 1'b0, 6'd5, 64'hDEAD_BEEF);
      sb_push(1'b1, 6'd5, 64'hDEAD_BEEF);
      @(negedge clk);
      drive_instr(1'b0, 1'b0, 1'b0, 6'd0, 64'd0);
      rd_a_idx = 6'd5;
      #1;
      checks++;
      if (rd_a_data !== 64'hDEAD_BEEF) begin
         failures++;
         $display("FAIL alu_bypass got=%h exp=%h", rd_a_data, 64'hDEAD_BEEF);
      end
      @(negedge clk);
      sb_pop();
      rd_a_idx = 6'd5;
      #1;
      checks++;
      if (rd_a_data !== model_rf[5]) begin
         failures++;
         $display("FAIL alu_rf5 got=%h exp=%h", rd_a_data, model_rf[5]);
      end
      checks++;
      if (retire_count !== model_cnt) begin
         failures++;
         $display("FAIL alu_count got=%0d exp=%0d", retire_count, model_cnt);
      end
   endtask

   task automatic test_load_stall();
      int stall_cycles;
      stall_cycles = 0;
      @(negedge clk);
      drive_instr(1'b1, 1'b1, 1'b1, 6'd9, 64'h0BAD);
      sb_push(1'b1, 6'd9, 64'h1234);
      // Next instruction is presented immediately and must be held off.
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         drive_instr(1'b1, 1'b1, 1'b0, 6'd10, 64'h55);
         wbi.mem_rdata_valid = 1'b0;
         wbi.mem_rdata       = 64'hFFFF;
         #1;
         if (wbi.stall === 1'b1) stall_cycles++;
         checks++;
         if (wbi.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL ld_ready_low cyc=%0d got=%b exp=0", c, wbi.in_ready);
         end
      end
      checks++;
      if (stall_cycles !== 3) begin
         failures++;
         $display("FAIL ld_stall_cycles got=%0d exp=3", stall_cycles);
      end
      @(negedge clk);
      wbi.mem_rdata_valid = 1'b1;
      wbi.mem_rdata       = 64'h1234;
      rd_b_idx            = 6'd9;
      #1;
      checks++;
      if (wbi.stall !== 1'b0 || wbi.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL ld_valid_stall got stall=%b ready=%b exp 0/1", wbi.stall, wbi.in_ready);
      end
      checks++;
      if (rd_b_data !== 64'h1234) begin
         failures++;
         $display("FAIL ld_bypass got=%h exp=%h", rd_b_data, 64'h1234);
      end
      sb_push(1'b1, 6'd10, 64'h55);
      @(negedge clk);
      drive_instr(1'b0, 1'b0, 1'b0, 6'd0, 64'd0);
      wbi.mem_rdata_valid = 1'b0;
      sb_pop();
      rd_a_idx = 6'd9;
      rd_b_idx = 6'd10;
      #1;
      checks++;
      if (rd_a_data !== model_rf[9]) begin
         failures++;
         $display("FAIL ld_rf9 got=%h exp=%h", rd_a_data, model_rf[9]);
      end
      checks++;
      if (rd_b_data !== 64'h55) begin
         failures++;
         $display("FAIL ld_next_accepted got=%h exp=%h", rd_b_data, 64'h55);
      end
      @(negedge clk);
      sb_pop();
      rd_a_idx = 6'd10;
      #1;
      checks++;
      if (rd_a_data !== model_rf[10]) begin
         failures++;
         $display("FAIL ld_rf10 got=%h exp=%h", rd_a_data, model_rf[10]);
      end
      checks++;
      if (retire_count !== model_cnt) begin
         failures++;
         $display("FAIL ld_count got=%0d exp=%0d", retire_count, model_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] base;
      base = model_cnt;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         drive_instr(1'b1, 1'b1, 1'b0, 6'(k), 64'(k * 32'h111));
         sb_push(1'b1, 6'(k), 64'(k * 32'h111));
         if (k == 3) begin
            sb_pop();
            rd_b_idx = 6'd1;
         end
         #1;
         checks++;
         if (wbi.stall !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stall k=%0d got=%b exp=0", k, wbi.stall);
         end
         if (k == 3) begin
            checks++;
            if (rd_b_data !== model_rf[1]) begin
               failures++;
               $display("FAIL b2b_rf1 got=%h exp=%h", rd_b_data, model_rf[1]);
            end
         end
      end
      @(negedge clk);
      drive_instr(1'b0, 1'b0, 1'b0, 6'd0, 64'd0);
      sb_pop();
      rd_a_idx = 6'd2;
      rd_b_idx = 6'd3;
      #1;
      checks++;
      if (rd_a_data !== model_rf[2]) begin
         failures++;
         $display("FAIL b2b_rf2_during_commit got=%h exp=%h", rd_a_data, model_rf[2]);
      end
      checks++;
      if (rd_b_data !== 64'h333) begin
         failures++;
         $display("FAIL b2b_bypass3 got=%h exp=%h", rd_b_data, 64'h333);
      end
      @(negedge clk);
      sb_pop();
      rd_a_idx = 6'd3;
      #1;
      checks++;
      if (rd_a_data !== model_rf[3]) begin
         failures++;
         $display("FAIL b2b_rf3 got=%h exp=%h", rd_a_data, model_rf[3]);
      end
      checks++;
      if (retire_count !== model_cnt || retire_count !== base + 32'd3) begin
         failures++;
         $display("FAIL b2b_count got=%0d exp=%0d", retire_count, model_cnt);
      end
   endtask

   task automatic test_reset_mid_load();
      @(negedge clk);
      drive_instr(1'b1, 1'b1, 1'b1, 6'd20, 64'h77);
      sb_push(1'b1, 6'd20, 64'hFF);
      @(negedge clk);
      drive_instr(1'b0, 1'b0, 1'b0, 6'd0, 64'd0);
      #1;
      checks++;
      if (wbi.stall !== 1'b1) begin
         failures++;
         $display("FAIL rst_ld_pending got=%b exp=1", wbi.stall);
      end
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (wbi.stall !== 1'b0 || retire_count !== model_cnt) begin
         failures++;
         $display("FAIL rst_async got stall=%b cnt=%0d exp stall=0 cnt=%0d",
                  wbi.stall, retire_count, model_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      wbi.mem_rdata_valid = 1'b1;
      wbi.mem_rdata       = 64'hFF;
      #1;
      checks++;
      if (wbi.stall !== 1'b0) begin
         failures++;
         $display("FAIL rst_late_valid_stall got=%b exp=0", wbi.stall);
      end
      @(negedge clk);
      wbi.mem_rdata_valid = 1'b0;
      rd_a_idx = 6'd20;
      rd_b_idx = 6'd5;
      #1;
      checks++;
      if (rd_a_data !== model_rf[20]) begin
         failures++;
         $display("FAIL rst_rf20 got=%h exp=%h", rd_a_data, model_rf[20]);
      end
      checks++;
      if (rd_b_data !== model_rf[5]) begin
         failures++;
         $display("FAIL rst_rf5_cleared got=%h exp=%h", rd_b_data, model_rf[5]);
      end
      checks++;
      if (retire_count !== model_cnt) begin
         failures++;
         $display("FAIL rst_count got=%0d exp=%0d", retire_count, model_cnt);
      end
   endtask

   task automatic test_wrap();
      @(negedge clk);
      force dut.retire_count_q = '1;
      #1;
      release dut.retire_count_q;
      model_cnt = '1;
      drive_instr(1'b1, 1'b0, 1'b0, 6'd7, 64'hABC);
      sb_push(1'b0, 6'd7, 64'hABC);
      @(negedge clk);
      drive_instr(1'b0, 1'b0, 1'b0, 6'd0, 64'd0);
      rd_a_idx = 6'd7;
      #1;
      checks++;
      if (rd_a_data !== 64'd0) begin
         failures++;
         $display("FAIL nop_no_bypass got=%h exp=0", rd_a_data);
      end
      @(negedge clk);
      sb_pop();
      #1;
      checks++;
      if (retire_count !== model_cnt) begin
         failures++;
         $display("FAIL wrap_count got=%h exp=%h", retire_count, model_cnt);
      end
      checks++;
      if (rd_a_data !== model_rf[7]) begin
         failures++;
         $display("FAIL nop_rf7 got=%h exp=%h", rd_a_data, model_rf[7]);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      rd_a_idx = '0;
      rd_b_idx = '0;
      drive_instr(1'b0, 1'b0, 1'b0, 6'd0, 64'd0);
      wbi.mem_rdata       = '0;
      wbi.mem_rdata_valid = 1'b0;
      model_reset();
      #1;
      test_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      test_alu();
      test_load_stall();
      test_back_to_back();
      test_reset_mid_load();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_commit_stage.md
# wb_commit_stage

Write-back commit stage of the 64-bit pipeline, directly downstream of the write-back decoder. It holds one in-flight instruction, merges ALU and memory-load results, and commits them to the 64 x 64-bit architectural register file. It stalls upstream while a load waits for memory data, provides two bypassed read ports to decode, and counts retired instructions.

## Interface
Parameters:
- NREGS, 64, number of architectural registers; index width is 6.
- XLEN, 64, data width.
- CNT_W, 32, retire-counter width.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  an instruction is presented for write-back.
- in_ready  out  1  stage accepts this cycle; equals ~stall.
- write_reg  in  1  decoded register-write enable.
- from_mem  in  1  the result comes from memory (LD).
- reg_index  in  6  destination register.
- alu_result  in  XLEN  ALU/MOV/LDI result.
- mem_rdata  in  XLEN  load data.
- mem_rdata_valid  in  1  mem_rdata is valid this cycle.
- stall  out  1  a held load is waiting for memory data.
- rd_a_idx, rd_b_idx  in  6 each  decode read indices.
- rd_a_data, rd_b_data  out  XLEN each  read data, bypassed.
- retire_count  out  CNT_W  completed instructions, wrapping.

## Operation
- FSM states:
  - IDLE: nothing held.
  - HOLD: a non-load is held.
  - WAIT_MEM: a load is held.
- Accept: on in_valid & in_ready, latch write_reg, from_mem, reg_index and alu_result into the stage register. The next state is WAIT_MEM if from_mem=1, otherwise HOLD.
- HOLD completes unconditionally on the next edge.
- WAIT_MEM completes on the first edge where mem_rdata_valid=1. mem_rdata_valid is ignored in IDLE and HOLD.
- Completion:
  - If write_reg_q=1, write RF[reg_index_q] with mem_rdata when from_mem_q=1, otherwise with alu_result_q.
  - retire_count increments by 1 whether or not a register is written; it wraps from 2^CNT_W-1 to 0.
- Back-to-back operation: a new instruction can be accepted on the same edge that completes the held one, giving 1 instruction/cycle throughput for non-loads. Next state after completion: HOLD or WAIT_MEM if a new instruction is accepted, else IDLE.
- stall = (state==WAIT_MEM) & ~mem_rdata_valid. It is combinational and in_ready = ~stall.
- Read ports are combinational.
  - If a committing write targets the same index this cycle, the port returns the write data (bypass). Otherwise it returns the RF contents.
  - Both ports may read the same index.
- No register is hardwired; index 0 is writable.
- Stores and the memory write enable are handled upstream; this stage never writes memory.

## Timing
- Reset (async assert, sync-style deassert handling not required here): state=IDLE, all 64 RF entries=0, retire_count=0, stage register=0, stall=0, in_ready=1.
- Latency from accept to RF visible:
  - Non-load: the write occurs at the edge after accept. The bypass exposes the data during the cycle before that edge.
  - Load: the write occurs at the edge where mem_rdata_valid=1, at least 1 cycle after accept.
- Reset mid-operation: a pending load is dropped, no write occurs, and the counter does not increment. A late mem_rdata_valid after reset is ignored because the state is IDLE.
- in_valid while stalled: the instruction is not latched; upstream must hold it.
- in_valid=1 with write_reg=0: still occupies the stage for one cycle and is counted.
- mem_rdata_valid with a simultaneous accept: completion and accept happen on the same edge.

## Structure
- Shared package pipe_pkg holds:
  - opcode constants: NOP 000000, MOV 000001, LD 000010, STR 000011, BEQ 000100, BNEQ 000101, ALU 000110, LDI 000111, STRI 001000;
  - the XLEN and register-index width constants;
  - the wb FSM state encoding.
- One sub-module, wb_regfile: 64 x XLEN, one write port and two combinational read ports with write-bypass, async reset to 0.
- The top level contains the FSM, the stage register, result muxing and the retire counter.

## Test plan
- Reset, then read all indices -> every read returns 0, retire_count=0, stall=0.
- Accept ALU op with write_reg=1, reg_index=5, alu_result=0xDEAD_BEEF -> during the following cycle rd_a_idx=5 returns 0xDEAD_BEEF via bypass; after the edge RF[5]=0xDEAD_BEEF and retire_count=1.
- Accept LD to reg 9, mem_rdata_valid low for 3 cycles then high with 0x1234 -> stall=1 for exactly 3 cycles, in_valid held upstream is not accepted, RF[9]=0x1234 at the valid edge, and the next instruction is accepted on that same edge.
- Back-to-back non-loads writing regs 1, 2, 3 on 3 consecutive cycles -> no stall, retire_count=3, and a read of reg 2 while reg 3 commits returns the reg 2 value.
- Load pending, assert rst_n=0, release, then pulse mem_rdata_valid with 0xFF -> RF target stays 0 and retire_count=0.
- Preload retire_count to all-ones (force), complete one NOP -> retire_count=0 and no RF write.
